partition_fixpoint_sequencer: RTL and testbench

- Sequential controller for a bank of NPART small partition counters, each WIDTH bits.
- Each counter has a 2-bit mode field; the XOR of the two mode bits selects hold (1) or increment-mod-2^WIDTH (0).
- Scheduler grants one active partition per cycle, round-robin, and advances it.
- Finishes when the bank reaches a fixpoint (no partition active) or when a step limit expires; reports final state and status to the checking logic.

---
 rtl/partition_fixpoint_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_partition_fixpoint_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/partition_fixpoint_sequencer.sv
// partition_fixpoint_sequencer: round-robin stepping of a bank of small
// partition counters until every partition holds (fixpoint) or a step limit
// expires.
// Optional build macro PFX_PERF_CNT_EN adds a 16-bit run_cycles busy-cycle
// counter output.
module partition_fixpoint_sequencer #(
    parameter int unsigned NPART  = 4,
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned STEP_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NPART*WIDTH-1:0]  init_val,
    input  logic [NPART*2-1:0]      init_mode,
    input  logic [NPART*WIDTH-1:0]  target,
    input  logic [STEP_W-1:0]       step_limit,
    output logic                    busy,
    output logic                    done,
    output logic                    fixpoint,
    output logic [NPART*WIDTH-1:0]  state_out,
    output logic [NPART-1:0]        grant,
    output logic [STEP_W-1:0]       steps
`ifdef PFX_PERF_CNT_EN
    ,
    output logic [15:0]             run_cycles
`endif
);

    localparam int unsigned PTR_W = (NPART > 1) ? $clog2(NPART) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    state_e                         state_q, state_d;
    logic [NPART-1:0][WIDTH-1:0]    counter_q, counter_d;
    logic [NPART-1:0][1:0]          mode_q, mode_d;
    logic [NPART-1:0][WIDTH-1:0]    target_q, target_d;
    logic [STEP_W-1:0]              limit_q, limit_d;
    logic [STEP_W-1:0]              steps_q, steps_d;
    logic [PTR_W-1:0]               ptr_q, ptr_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           fix_q, fix_d;

    logic [NPART-1:0]               active_c;
    logic                           grant_found_c;
    logic [PTR_W-1:0]               grant_idx_c;
    logic [NPART-1:0]               grant_c;

    // Active partitions: equal mode bits mean the partition still advances.
    always_comb begin
        active_c = '0;
        for (int unsigned p = 0; p < NPART; p++) begin
            active_c[PTR_W'(p)] = ~(mode_q[PTR_W'(p)][0] ^ mode_q[PTR_W'(p)][1]);
        end
    end

    // Cyclic search for the first active partition at or after the pointer.
    always_comb begin
        int unsigned cand;
        grant_found_c = 1'b0;
        grant_idx_c   = '0;
        cand          = 0;
        for (int unsigned i = 0; i < NPART; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NPART) begin
                cand = cand - NPART;
            end
            if (!grant_found_c && active_c[PTR_W'(cand)]) begin
                grant_found_c = 1'b1;
                grant_idx_c   = PTR_W'(cand);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath next values and the combinational grant.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        mode_d    = mode_q;
        target_d  = target_q;
        limit_d   = limit_q;
        steps_d   = steps_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        fix_d     = fix_q;
        grant_c   = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    counter_d = init_val;
                    mode_d    = init_mode;
                    target_d  = target;
                    limit_d   = step_limit;
                    steps_d   = '0;
                    ptr_d     = '0;
                    busy_d    = 1'b1;
                    fix_d     = 1'b0;
                end
            end
            ST_LOAD: begin
                // Partitions already at their target are forced to hold.
                for (int unsigned p = 0; p < NPART; p++) begin
                    if (counter_q[PTR_W'(p)] == target_q[PTR_W'(p)]) begin
                        mode_d[PTR_W'(p)] = 2'b01;
                    end
                end
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (active_c == '0) begin
                    state_d = ST_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    fix_d   = 1'b1;
                end else if (steps_q == limit_q) begin
                    state_d = ST_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    fix_d   = 1'b0;
                end else if (grant_found_c) begin
                    grant_c[grant_idx_c]   = 1'b1;
                    counter_d[grant_idx_c] = counter_q[grant_idx_c] + WIDTH'(1);
                    if (counter_d[grant_idx_c] == target_q[grant_idx_c]) begin
                        mode_d[grant_idx_c] = 2'b01;
                    end
                    steps_d = (&steps_q) ? steps_q : steps_q + STEP_W'(1);
                    ptr_d   = (grant_idx_c == PTR_W'(NPART - 1)) ? '0
                                                                : grant_idx_c + PTR_W'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_q <= '0;
            mode_q    <= '0;
            target_q  <= '0;
            limit_q   <= '0;
            steps_q   <= '0;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fix_q     <= 1'b0;
        end else begin
            counter_q <= counter_d;
            mode_q    <= mode_d;
            target_q  <= target_d;
            limit_q   <= limit_d;
            steps_q   <= steps_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fix_q     <= fix_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fixpoint  = fix_q;
    assign state_out = counter_q;
    assign grant     = grant_c;
    assign steps     = steps_q;

`ifdef PFX_PERF_CNT_EN
    logic [15:0] run_cycles_q, run_cycles_d;

    // Busy-cycle counter: clears on an accepted start, saturates, holds after done.
    always_comb begin
        run_cycles_d = run_cycles_q;
        if (state_q == ST_IDLE && start) begin
            run_cycles_d = '0;
        end else if (busy_q && run_cycles_q != 16'hFFFF) begin
            run_cycles_d = run_cycles_q + 16'd1;
        end
    end

    // Busy-cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cycles_q <= '0;
        end else begin
            run_cycles_q <= run_cycles_d;
        end
    end

    assign run_cycles = run_cycles_q;
`endif

endmodule

// File: tb/tb_partition_fixpoint_sequencer.sv
// Testbench for partition_fixpoint_sequencer: directed and random runs
// compared cycle by cycle against a behavioural run model.
module tb_partition_fixpoint_sequencer;

    localparam int NPART  = 4;
    localparam int WIDTH  = 3;
    localparam int STEP_W = 8;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic [NPART*WIDTH-1:0]  init_val = '0;
    logic [NPART*2-1:0]      init_mode = '0;
    logic [NPART*WIDTH-1:0]  target = '0;
    logic [STEP_W-1:0]       step_limit = '0;
    logic                    busy;
    logic                    done;
    logic                    fixpoint;
    logic [NPART*WIDTH-1:0]  state_out;
    logic [NPART-1:0]        grant;
    logic [STEP_W-1:0]       steps;
`ifdef PFX_PERF_CNT_EN
    logic [15:0]             run_cycles;
`endif

    int errors = 0;
    int checks = 0;

    partition_fixpoint_sequencer #(
        .NPART (NPART),
        .WIDTH (WIDTH),
        .STEP_W(STEP_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .init_val  (init_val),
        .init_mode (init_mode),
        .target    (target),
        .step_limit(step_limit),
        .busy      (busy),
        .done      (done),
        .fixpoint  (fixpoint),
        .state_out (state_out),
        .grant     (grant),
        .steps     (steps)
`ifdef PFX_PERF_CNT_EN
        ,
        .run_cycles(run_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Everything observable must be zero while reset is asserted.
    task automatic chk_zero(input string name);
        chk({name, " busy"}, 32'(busy), 0);
        chk({name, " done"}, 32'(done), 0);
        chk({name, " fixpoint"}, 32'(fixpoint), 0);
        chk({name, " state_out"}, 32'(state_out), 0);
        chk({name, " grant"}, 32'(grant), 0);
        chk({name, " steps"}, 32'(steps), 0);
    endtask

    // Assert reset mid-cycle, check outputs at once, release on a later negedge.
    task automatic do_reset(input string name);
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk_zero(name);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk({name, " no done after reset"}, 32'(done), 0);
            chk({name, " idle after reset"}, 32'(busy), 0);
        end
    endtask

    // One full run: model the expected grant sequence, then follow the DUT cycle by cycle.
    task automatic run_case(input string name,
                            input logic [NPART*WIDTH-1:0] v,
                            input logic [NPART*2-1:0] m,
                            input logic [NPART*WIDTH-1:0] t,
                            input logic [STEP_W-1:0] lim,
                            input bit hold_start);
        int cnt[NPART];
        int tg[NPART];
        bit hld[NPART];
        int gq[$];
        int ptr;
        int g;
        bit fix;
        bit all_held;
        logic [NPART*WIDTH-1:0] fin;

        for (int p = 0; p < NPART; p++) begin
            cnt[p] = int'(v[p*WIDTH +: WIDTH]);
            tg[p]  = int'(t[p*WIDTH +: WIDTH]);
            hld[p] = (m[2*p] != m[2*p+1]) || (cnt[p] == tg[p]);
        end
        ptr = 0;
        fix = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            all_held = 1'b1;
            for (int p = 0; p < NPART; p++) if (!hld[p]) all_held = 1'b0;
            if (all_held) begin
                fix = 1'b1;
                break;
            end
            if (gq.size() == int'(lim)) begin
                fix = 1'b0;
                break;
            end
            g = -1;
            for (int i = 0; i < NPART; i++) begin
                if (g < 0 && !hld[(ptr + i) % NPART]) g = (ptr + i) % NPART;
            end
            cnt[g] = (cnt[g] + 1) % (1 << WIDTH);
            if (cnt[g] == tg[g]) hld[g] = 1'b1;
            gq.push_back(g);
            ptr = (g + 1) % NPART;
        end
        for (int p = 0; p < NPART; p++) fin[p*WIDTH +: WIDTH] = WIDTH'(cnt[p]);

        @(negedge clk);
        init_val   = v;
        init_mode  = m;
        target     = t;
        step_limit = lim;
        start      = 1'b1;
        @(negedge clk);
        chk({name, " load busy"}, 32'(busy), 1);
        chk({name, " load grant"}, 32'(grant), 0);
        if (hold_start) begin
            init_val   = NPART*WIDTH'($urandom);
            init_mode  = NPART*2'($urandom);
            target     = NPART*WIDTH'($urandom);
            step_limit = STEP_W'($urandom);
        end else begin
            start = 1'b0;
        end
        for (int k = 0; k < gq.size(); k++) begin
            @(negedge clk);
            chk($sformatf("%s grant#%0d", name, k), 32'(grant), 32'(1) << gq[k]);
            chk($sformatf("%s steps#%0d", name, k), 32'(steps), 32'(k));
            chk($sformatf("%s busy#%0d", name, k), 32'(busy), 1);
        end
        @(negedge clk);
        chk({name, " last run grant"}, 32'(grant), 0);
        chk({name, " last run busy"}, 32'(busy), 1);
        chk({name, " last run done"}, 32'(done), 0);
        @(negedge clk);
        chk({name, " fin done"}, 32'(done), 1);
        chk({name, " fin busy"}, 32'(busy), 0);
        chk({name, " fin fixpoint"}, 32'(fixpoint), 32'(fix));
        chk({name, " fin steps"}, 32'(steps), 32'(gq.size()));
        chk({name, " fin state"}, 32'(state_out), 32'(fin));
`ifdef PFX_PERF_CNT_EN
        chk({name, " run_cycles"}, 32'(run_cycles), 32'(gq.size() + 2));
`endif
        @(negedge clk);
        chk({name, " post done"}, 32'(done), 0);
        chk({name, " post busy"}, 32'(busy), 0);
        chk({name, " post fixpoint held"}, 32'(fixpoint), 32'(fix));
        chk({name, " post state"}, 32'(state_out), 32'(fin));
        if (hold_start) begin
            @(negedge clk);
            chk({name, " restart busy"}, 32'(busy), 1);
            chk({name, " restart fixpoint cleared"}, 32'(fixpoint), 0);
            do_reset({name, " cleanup"});
        end
    endtask

    initial begin
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle");

        run_case("immediate_fix", 12'h5A3, 8'h00, 12'h5A3, 8'd50, 1'b0);
        run_case("wrap", 12'h180, 8'h51, 12'h040, 8'd100, 1'b0);
        run_case("round_robin", 12'h000, 8'h00, 12'h492, 8'd100, 1'b0);
        run_case("timeout", 12'h000, 8'h54, 12'h005, 8'd3, 1'b0);
        run_case("limit_zero", 12'h000, 8'hFF, 12'hFFF, 8'd0, 1'b0);

        for (int r = 0; r < 24; r++) begin
            run_case($sformatf("rand%0d", r), 12'($urandom), 8'($urandom),
                     12'($urandom), 8'($urandom_range(0, 40)), 1'b0);
        end

        run_case("start_held", 12'h000, 8'h00, 12'h049, 8'd100, 1'b1);

        // Reset in the middle of a long run.
        @(negedge clk);
        init_val   = '0;
        init_mode  = '0;
        target     = 12'hFFF;
        step_limit = 8'd100;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrun busy", 32'(busy), 1);
        do_reset("midrun");

        run_case("after_reset", 12'h000, 8'h00, 12'h492, 8'd5, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
